mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Initiator for the 2048x8 multi-bank memory (ren/wen, waddr/raddr, din/dout, 1-cycle read).
//  Accepts write and read requests from clients over valid/ready and arbitrates them.
//  Never drives ren and wen together; the memory ignores that case.
//  Captures mem_dout on the cycle after each read and returns it through a buffered response port.
// PARAMETERS
//  AW        11  address width (2 bank bits, 2 sub-bank bits, 7 word bits)
//  DW        8   data width
//  RSP_DEPTH 4   response FIFO entries; also the cap on reads outstanding + buffered (>=2)
// PORTS
//  clk        in   1   sole clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  wr_valid   in   1   write request present
//  wr_ready   out  1   write accepted when wr_valid&wr_ready at posedge
//  wr_addr    in   AW  write address
//  wr_data    in   DW  write data
//  rd_valid   in   1   read request present
//  rd_ready   out  1   read accepted when rd_valid&rd_ready at posedge
//  rd_addr    in   AW  read address
//  rsp_valid  out  1   read data available
//  rsp_ready  in   1   consumer takes rsp_data when rsp_valid&rsp_ready at posedge
//  rsp_data   out  DW  read data, in read-acceptance order
//  rsp_addr   out  AW  address that produced rsp_data
//  mem_ren    out  1   memory read enable, registered
//  mem_wen    out  1   memory write enable, registered
//  mem_raddr  out  AW  memory read address, registered
//  mem_waddr  out  AW  memory write address, registered
//  mem_din    out  DW  memory write data, registered
//  mem_dout   in   DW  memory read data; valid the cycle after mem_ren, 0 otherwise
// BEHAVIOUR
//  - Reset: mem_ren=mem_wen=0; mem_raddr, mem_waddr and mem_din =0.
//    FIFO empty and rsp_valid=0; rsp_data and rsp_addr =0.
//    In-flight flags cleared; last_grant=WRITE, so the next contested grant goes to read.
//  - Reset mid-operation drops all in-flight and buffered reads. Writes already
//    clocked into the memory stay in the memory.
//  - Credit: cnt = cmd_rd_flag + mem_rd_flag + fifo_count. A read may be granted only if cnt < RSP_DEPTH.
//  - Grant, evaluated each cycle with at most one grant per cycle:
//    - only wr_valid: grant write.
//    - only rd_valid with credit available: grant read.
//    - both, with credit: grant the opposite of last_grant, then update last_grant.
//    - both, no credit: grant write.
//  - wr_ready and rd_ready are combinational and equal the grant. They do not depend on
//    their own valid, except through arbitration.
//  - Pipeline for a read accepted at edge E0:
//    - cycle 1: mem_ren=1 and mem_raddr=addr; addr is also copied into a pipe register.
//    - memory samples at edge E1; mem_dout is valid in cycle 2.
//    - at E2 the FIFO pushes {addr, mem_dout}.
//    - rsp_valid rises in cycle 3 at the earliest. Accept-to-rsp_valid latency is 3 cycles.
//  - Write accepted at E0: mem_wen=1 in cycle 1 with mem_waddr and mem_din.
//    Exactly one-cycle pulse per request.
//  - Order: a read accepted after a write to the same address returns the new data.
//    The memory updates at the write edge, before the read issues.
//  - mem_ren/mem_wen return to 0 in any cycle following no grant.
//    Back-to-back grants give continuous pulses.
//  - FIFO: push and pop in the same cycle are allowed when full.
//    Credit guarantees no push is ever attempted while the FIFO is full.
//  - mem_dout is sampled only when mem_rd_flag=1. Idle zeros are never pushed.
//  - Widths: all address and data paths pass through unmodified. No arithmetic on data.
//    FIFO pointers are clog2(RSP_DEPTH) bits and wrap modulo RSP_DEPTH.
// STRUCTURE
//  - Shared package mem_pkg: MEM_AW=11, MEM_DW=8, BANK_MSB=10, SUBBANK_MSB=8,
//    GRANT_RD/GRANT_WR encoding.
//  - One sub-module: mem_rsp_fifo (sync FIFO; DEPTH, width AW+DW; push/pop/full/empty/count).
//  - Arbiter, credit counter and pipe flags live in mem_access_ctrl.
// TESTING
//  1 Reset: assert rst 2 cycles with wr_valid=rd_valid=1.
//    -> mem_ren=mem_wen=0, rsp_valid=0, no grant during reset.
//  2 Write 8'hA5 @11'h123, then read @11'h123.
//    -> mem_wen pulse 1 cycle; rsp_valid 3 cycles after read accept;
//       rsp_data=A5, rsp_addr=123.
//  3 wr_valid and rd_valid both held 6 cycles, credit available.
//    -> grants alternate R,W,R,W,R,W; mem_ren&mem_wen never both 1.
//  4 rsp_ready=0 with 6 reads to 11'h000..11'h005, each pre-written with value = addr+1.
//    -> exactly 4 accepted, then rd_ready=0.
//    -> raising rsp_ready returns 01,02,03,04 in order, then the remaining 2 are accepted.
//  5 Bank/sub-bank corners: write/read 11'h07F, 11'h080, 11'h1FF, 11'h200, 11'h7FF
//    with distinct data. -> each read returns its own data.
//  6 rst asserted the cycle after a read accept. -> no rsp_valid afterwards.
//    -> FIFO empty, rd_ready=1 after reset.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, bank field positions and grant encoding for the memory initiator
package mem_pkg;
  localparam int MEM_AW = 11;
  localparam int MEM_DW = 8;
  localparam int BANK_MSB = 10;
  localparam int SUBBANK_MSB = 8;
  typedef enum logic {GRANT_WR = 1'b0, GRANT_RD = 1'b1} grant_e;
endpackage

// File: rtl/mem_rsp_fifo.sv
// mem_rsp_fifo: synchronous FIFO buffering {addr, data} read responses
// ports: clk/rst; push+din write side; pop+dout read side (dout is 0 when empty); full, empty, count status
module mem_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 19
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] ram_q [DEPTH];
  logic [W-1:0] ram_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == CW'(DEPTH);
    do_pop = pop & !empty;
    do_push = push & (!full | do_pop);
    ram_d = ram_q;
    if (do_push) ram_d[wr_q] = din;
    wr_d = do_push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + PW'(1)) : wr_q;
    rd_d = do_pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + PW'(1)) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    dout = empty ? '0 : ram_q[rd_q];
    count = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      ram_q <= ram_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: arbitrates client writes/reads onto a 1-cycle-read memory and buffers read responses
// ports: clk/rst; wr_* and rd_* request channels (valid/ready); rsp_* response channel;
//        mem_ren/wen/raddr/waddr/din registered memory commands; mem_dout memory read data
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW,
  parameter int RSP_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] rsp_addr,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [AW-1:0] mem_raddr,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);
  localparam int CW = $clog2(RSP_DEPTH + 3);
  localparam int FCW = $clog2(RSP_DEPTH + 1);
  grant_e last_q, last_d;
  logic mem_ren_q, mem_ren_d, mem_wen_q, mem_wen_d, rd_flag_q, rd_flag_d;
  logic [AW-1:0] mem_raddr_q, mem_raddr_d, mem_waddr_q, mem_waddr_d, rd_addr_q, rd_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic [CW-1:0] cnt;
  logic [FCW-1:0] fifo_count;
  logic fifo_full, fifo_empty, rd_ok, wr_ok, grant_rd, grant_wr;
  logic [AW+DW-1:0] fifo_dout;
  mem_rsp_fifo #(.DEPTH(RSP_DEPTH), .W(AW + DW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(rd_flag_q),
    .pop(rsp_ready),
    .din({rd_addr_q, mem_dout}),
    .dout(fifo_dout),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
  always_comb begin
    // every read in the pipe already owns a FIFO slot, so pushes never hit a full FIFO
    cnt = CW'(mem_ren_q) + CW'(rd_flag_q) + CW'(fifo_count);
    rd_ok = rd_valid & !rst & !fifo_full & (cnt < CW'(RSP_DEPTH));
    wr_ok = wr_valid & !rst;
    grant_rd = rd_ok & (!wr_ok | last_q == GRANT_WR);
    grant_wr = wr_ok & !grant_rd;
    // only contested cycles flip the round-robin pointer
    last_d = (rd_ok & wr_ok) ? (grant_rd ? GRANT_RD : GRANT_WR) : last_q;
    mem_ren_d = grant_rd;
    mem_wen_d = grant_wr;
    mem_raddr_d = grant_rd ? rd_addr : mem_raddr_q;
    mem_waddr_d = grant_wr ? wr_addr : mem_waddr_q;
    mem_din_d = grant_wr ? wr_data : mem_din_q;
    rd_flag_d = mem_ren_q;
    rd_addr_d = mem_ren_q ? mem_raddr_q : rd_addr_q;
    wr_ready = grant_wr;
    rd_ready = grant_rd;
    rsp_valid = !fifo_empty;
    {rsp_addr, rsp_data} = fifo_dout;
    mem_ren = mem_ren_q;
    mem_wen = mem_wen_q;
    mem_raddr = mem_raddr_q;
    mem_waddr = mem_waddr_q;
    mem_din = mem_din_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GRANT_WR;
      mem_ren_q <= 1'b0;
      mem_wen_q <= 1'b0;
      mem_raddr_q <= '0;
      mem_waddr_q <= '0;
      mem_din_q <= '0;
      rd_flag_q <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      last_q <= last_d;
      mem_ren_q <= mem_ren_d;
      mem_wen_q <= mem_wen_d;
      mem_raddr_q <= mem_raddr_d;
      mem_waddr_q <= mem_waddr_d;
      mem_din_q <= mem_din_d;
      rd_flag_q <= rd_flag_d;
      rd_addr_q <= rd_addr_d;
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed tests of mem_access_ctrl against a behavioural 2048x8 memory
module tb_mem_access_ctrl;
  logic clk, rst, wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, rsp_ready;
  logic [10:0] wr_addr, rd_addr, rsp_addr, mem_raddr, mem_waddr;
  logic [7:0] wr_data, rsp_data, mem_din, mem_dout;
  logic mem_ren, mem_wen;
  logic [7:0] tb_mem [2048];
  logic [10:0] ca [5];
  logic [7:0] cd [5];
  int vectors = 0;
  int miscompares = 0;
  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_wen) tb_mem[mem_waddr] <= mem_din;
    mem_dout <= mem_ren ? tb_mem[mem_raddr] : 8'h00;
  end
  task automatic do_reset();
    rst = 1; wr_valid = 0; rd_valid = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;
  endtask
  task automatic do_write(input logic [10:0] a, input logic [7:0] d);
    int n = 0;
    wr_valid = 1; wr_addr = a; wr_data = d;
    #1;
    while (!wr_ready && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL wr_accept_timeout addr=%h got wr_ready=%b want 1", a, wr_ready); end
    @(negedge clk);
    wr_valid = 0;
  endtask
  task automatic read_one(input logic [10:0] a, output logic [7:0] d, output logic [10:0] ra);
    int n = 0;
    rd_valid = 1; rd_addr = a;
    #1;
    while (!rd_ready && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (rd_ready !== 1'b1) begin miscompares++; $display("FAIL rd_accept_timeout addr=%h got rd_ready=%b want 1", a, rd_ready); end
    @(negedge clk);
    rd_valid = 0; n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL rsp_timeout addr=%h got rsp_valid=%b want 1", a, rsp_valid); end
    d = rsp_data; ra = rsp_addr;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask
  task automatic test_reset();
    rst = 1; wr_valid = 1; rd_valid = 1; rsp_ready = 0;
    wr_addr = 11'h001; wr_data = 8'hFF; rd_addr = 11'h002;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if ({mem_ren, mem_wen} !== 2'b00) begin miscompares++; $display("FAIL reset_en got ren,wen=%b want 00", {mem_ren, mem_wen}); end
      vectors++;
      if ({wr_ready, rd_ready} !== 2'b00) begin miscompares++; $display("FAIL reset_grant got wr,rd ready=%b want 00", {wr_ready, rd_ready}); end
      vectors++;
      if ({rsp_valid, rsp_addr, rsp_data} !== 20'h0) begin miscompares++; $display("FAIL reset_rsp got v=%b a=%h d=%h want 0", rsp_valid, rsp_addr, rsp_data); end
    end
    vectors++;
    if ({mem_raddr, mem_waddr, mem_din} !== 30'h0) begin miscompares++; $display("FAIL reset_mem_bus got %h %h %h want 0", mem_raddr, mem_waddr, mem_din); end
    rst = 0; wr_valid = 0; rd_valid = 0;
  endtask
  task automatic test_write_read();
    rsp_ready = 0;
    do_write(11'h123, 8'hA5);
    vectors++;
    if ({mem_wen, mem_waddr, mem_din} !== {1'b1, 11'h123, 8'hA5}) begin miscompares++; $display("FAIL wr_cmd got wen=%b a=%h d=%h want 1 123 a5", mem_wen, mem_waddr, mem_din); end
    vectors++;
    if (mem_ren !== 1'b0) begin miscompares++; $display("FAIL wr_no_ren got %b want 0", mem_ren); end
    @(negedge clk);
    vectors++;
    if (mem_wen !== 1'b0) begin miscompares++; $display("FAIL wr_pulse_end got %b want 0", mem_wen); end
    rd_valid = 1; rd_addr = 11'h123;
    #1;
    vectors++;
    if (rd_ready !== 1'b1) begin miscompares++; $display("FAIL rd_ready got %b want 1", rd_ready); end
    @(negedge clk);
    rd_valid = 0;
    vectors++;
    if ({mem_ren, mem_raddr, rsp_valid} !== {1'b1, 11'h123, 1'b0}) begin miscompares++; $display("FAIL rd_cmd got ren=%b a=%h rv=%b want 1 123 0", mem_ren, mem_raddr, rsp_valid); end
    @(negedge clk);
    vectors++;
    if ({mem_ren, rsp_valid} !== 2'b00) begin miscompares++; $display("FAIL rd_cycle2 got ren,rv=%b want 00", {mem_ren, rsp_valid}); end
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_addr, rsp_data} !== {1'b1, 11'h123, 8'hA5}) begin miscompares++; $display("FAIL rd_rsp got v=%b a=%h d=%h want 1 123 a5", rsp_valid, rsp_addr, rsp_data); end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    vectors++;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rsp_pop got %b want 0", rsp_valid); end
  endtask
  task automatic test_alternate();
    do_reset();
    rsp_ready = 1; wr_valid = 1; rd_valid = 1;
    wr_addr = 11'h300; wr_data = 8'h11; rd_addr = 11'h123;
    #1;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if ({rd_ready, wr_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL alt_grant[%0d] got rd,wr=%b want %b", i, {rd_ready, wr_ready}, (i % 2 == 0) ? 2'b10 : 2'b01); end
      vectors++;
      if (mem_ren & mem_wen) begin miscompares++; $display("FAIL alt_excl[%0d] got ren&wen=1 want 0", i); end
      @(negedge clk);
    end
    wr_valid = 0; rd_valid = 0;
    repeat (5) @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL alt_drain got rsp_valid=%b want 0", rsp_valid); end
    vectors++;
    if (tb_mem[11'h300] !== 8'h11) begin miscompares++; $display("FAIL alt_write got %h want 11", tb_mem[11'h300]); end
    rsp_ready = 0;
  endtask
  task automatic test_credit();
    int k = 0;
    int n = 0;
    logic acc;
    rsp_ready = 0;
    for (int a = 0; a < 6; a++) do_write(11'(a), 8'(a + 1));
    @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      rd_valid = k < 6; rd_addr = 11'(k);
      #1;
      acc = rd_valid & rd_ready;
      @(negedge clk);
      if (acc) k++;
    end
    vectors++;
    if (k !== 4) begin miscompares++; $display("FAIL credit_accepts got %0d want 4", k); end
    vectors++;
    if ({rd_valid, rd_ready, rsp_valid} !== 3'b101) begin miscompares++; $display("FAIL credit_stall got valid,ready,rsp_valid=%b want 101", {rd_valid, rd_ready, rsp_valid}); end
    rsp_ready = 1;
    for (int c = 0; c < 40 && n < 6; c++) begin
      rd_valid = k < 6; rd_addr = 11'(k);
      #1;
      acc = rd_valid & rd_ready;
      if (rsp_valid) begin
        vectors++;
        if ({rsp_addr, rsp_data} !== {11'(n), 8'(n + 1)}) begin miscompares++; $display("FAIL credit_rsp[%0d] got a=%h d=%h want %h %h", n, rsp_addr, rsp_data, 11'(n), 8'(n + 1)); end
        n++;
      end
      @(negedge clk);
      if (acc) k++;
    end
    rd_valid = 0; rsp_ready = 0;
    vectors++;
    if ({k, n} !== {32'd6, 32'd6}) begin miscompares++; $display("FAIL credit_total got accepted=%0d returned=%0d want 6 6", k, n); end
  endtask
  task automatic test_corners();
    logic [7:0] d;
    logic [10:0] ra;
    ca[0] = 11'h07F; ca[1] = 11'h080; ca[2] = 11'h1FF; ca[3] = 11'h200; ca[4] = 11'h7FF;
    cd[0] = 8'h3C; cd[1] = 8'hC3; cd[2] = 8'h5A; cd[3] = 8'h96; cd[4] = 8'h69;
    rsp_ready = 0;
    for (int i = 0; i < 5; i++) do_write(ca[i], cd[i]);
    for (int i = 0; i < 5; i++) begin
      read_one(ca[i], d, ra);
      vectors++;
      if ({ra, d} !== {ca[i], cd[i]}) begin miscompares++; $display("FAIL corner[%0d] got a=%h d=%h want %h %h", i, ra, d, ca[i], cd[i]); end
    end
  endtask
  task automatic test_reset_midflight();
    rsp_ready = 1; rd_valid = 1; rd_addr = 11'h07F;
    #1;
    vectors++;
    if (rd_ready !== 1'b1) begin miscompares++; $display("FAIL mid_accept got %b want 1", rd_ready); end
    @(negedge clk);
    rd_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    vectors++;
    if (mem_ren !== 1'b0) begin miscompares++; $display("FAIL mid_ren got %b want 0", mem_ren); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rsp[%0d] got %b want 0", i, rsp_valid); end
    end
    rd_valid = 1; rd_addr = 11'h000;
    #1;
    vectors++;
    if ({rd_ready, wr_ready} !== 2'b10) begin miscompares++; $display("FAIL mid_ready got rd,wr=%b want 10", {rd_ready, wr_ready}); end
    rd_valid = 0; rsp_ready = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_credit();
    test_corners();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
